// File: rtl/fsub_issue.sv
// Issue/retire wrapper around a combinational fp32 subtractor.
// Ports: request handshake in, subtractor x1/x2/y/ovf, result FIFO out,
//        sticky overflow status and in-flight occupancy.
module fsub_issue #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      sub_x1,
  output logic [31:0]      sub_x2,
  input  logic [31:0]      sub_y,
  input  logic             sub_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_ovf,
  output logic [TAG_W-1:0] res_tag,
  output logic             ovf_sticky,
  input  logic             ovf_clear,
  output logic [1:0]       inflight
);

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      x1_q, x2_q;
  logic [TAG_W-1:0] tag1_q;

  logic [31:0]      fd_q [2];
  logic             fo_q [2];
  logic [TAG_W-1:0] ft_q [2];
  logic             wp_q, rp_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             sticky_q, sticky_d;

  logic accept, pop, s1_drain;

  assign res_valid = (cnt_q != 2'd0);
  assign pop       = res_valid & res_ready;
  // A full FIFO can still take S1 when the head leaves this cycle.
  assign s1_drain  = s1_valid_q & ((cnt_q != 2'd2) | pop);
  assign req_ready = ~s1_valid_q | s1_drain;
  assign accept    = req_valid & req_ready;

  assign sub_x1     = x1_q;
  assign sub_x2     = x2_q;
  assign res_data   = fd_q[rp_q];
  assign res_ovf    = fo_q[rp_q];
  assign res_tag    = ft_q[rp_q];
  assign ovf_sticky = sticky_q;
  assign inflight   = cnt_q + {1'b0, s1_valid_q};

  always_comb begin
    s1_valid_d = accept | (s1_valid_q & ~s1_drain);
    cnt_d      = cnt_q;
    unique case ({s1_drain, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    // Set has priority over clear.
    sticky_d = (s1_drain & sub_ovf) | (sticky_q & ~ovf_clear);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      x1_q       <= '0;
      x2_q       <= '0;
      tag1_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        fd_q[i] <= '0;
        fo_q[i] <= 1'b0;
        ft_q[i] <= '0;
      end
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      cnt_q      <= 2'd0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        x1_q   <= req_a;
        // Add = subtract with B's sign flipped; payload untouched.
        x2_q   <= req_op ? {~req_b[31], req_b[30:0]} : req_b;
        tag1_q <= req_tag;
      end
      if (s1_drain) begin
        fd_q[wp_q] <= sub_y;
        fo_q[wp_q] <= sub_ovf;
        ft_q[wp_q] <= tag1_q;
        wp_q       <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_fsub_issue.sv
// Bench for fsub_issue: stand-in fp32 subtractor, directed table,
// backpressure/stream/reset sequences and a random scoreboard run.
module tb_fsub_issue;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_op;
  logic [31:0] req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic [31:0] sub_x1, sub_x2, sub_y;
  logic sub_ovf;
  logic res_valid, res_ready;
  logic [31:0] res_data;
  logic res_ovf;
  logic [TAG_W-1:0] res_tag;
  logic ovf_sticky, ovf_clear;
  logic [1:0] inflight;

  always #5 clk = ~clk;

  fsub_issue #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_tag(req_tag),
    .sub_x1(sub_x1), .sub_x2(sub_x2),
    .sub_y(sub_y), .sub_ovf(sub_ovf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf),
    .res_tag(res_tag),
    .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear),
    .inflight(inflight)
  );

  // fp32 <-> real helpers (normals only; subnormals flush to zero)
  function automatic real s2r(logic [31:0] f);
    logic [63:0] b;
    if (f[30:23] == 8'd0) return 0.0;
    b = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [32:0] r2s(real r);
    logic [63:0] b;
    int e;
    logic [31:0] v;
    logic rnd;
    b = $realtobits(r);
    e = int'(b[62:52]) - 896;
    if (b[62:52] == 11'd0 || e <= 0) return {1'b0, b[63], 31'd0};
    if (e >= 255) return {1'b1, b[63], 8'hFF, 23'd0};
    rnd = b[28] & ((|b[27:0]) | b[29]);
    v = {b[63], e[7:0], b[51:29]} + 32'(rnd);
    return {(v[30:23] == 8'hFF), v};
  endfunction

  function automatic logic is_spec(logic [31:0] f);
    return f[30:23] == 8'hFF;
  endfunction

  // stand-in combinational subtractor
  always_comb begin
    if (is_spec(sub_x1) || is_spec(sub_x2))
      {sub_ovf, sub_y} = {1'b0, 32'h7FC00000};
    else
      {sub_ovf, sub_y} = r2s(s2r(sub_x1) - s2r(sub_x2));
  end

  typedef struct packed {
    logic [31:0] d;
    logic o;
    logic [TAG_W-1:0] t;
  } res_t;

  // reference: the arithmetic the op asks for
  function automatic res_t ref_op(logic op, logic [31:0] a,
                                  logic [31:0] b, logic [TAG_W-1:0] t);
    res_t r;
    logic [32:0] s;
    if (is_spec(a) || is_spec(b)) s = {1'b0, 32'h7FC00000};
    else if (op) s = r2s(s2r(a) + s2r(b));
    else s = r2s(s2r(a) - s2r(b));
    r.o = s[32];
    r.d = s[31:0];
    r.t = t;
    return r;
  endfunction

  int checks = 0;
  int errors = 0;
  res_t q[$];
  int held = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // one clock: sample handshakes before the edge, update model after
  task automatic cycle(output logic acc, output logic pop);
    res_t e;
    @(negedge clk);
    chk("inflight", 64'(inflight), 64'(held));
    chk("req_ready", 64'(req_ready),
        64'(!(held == 3 && !res_ready)));
    acc = req_valid && req_ready;
    pop = res_valid && res_ready;
    if (pop) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty actual=1 required=0");
      end else begin
        e = q.pop_front();
        chk("res_data", 64'(res_data), 64'(e.d));
        chk("res_ovf", 64'(res_ovf), 64'(e.o));
        chk("res_tag", 64'(res_tag), 64'(e.t));
      end
      held--;
    end
    if (acc) begin
      q.push_back(ref_op(req_op, req_a, req_b, req_tag));
      held++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    logic a, p;
    cycle(a, p);
  endtask

  function automatic logic [31:0] rnd_norm();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)),
            23'($urandom)};
  endfunction

  task automatic set_req(logic op, logic [31:0] a, logic [31:0] b,
                         logic [TAG_W-1:0] t);
    req_op = op;
    req_a = a;
    req_b = b;
    req_tag = t;
  endtask

  typedef struct {
    logic op;
    logic [31:0] a, b;
    logic [TAG_W-1:0] tag;
    logic [31:0] x2, d;
    logic o, clr, st;
  } vec_t;

  vec_t tbl[9];

  task automatic apply_vec(vec_t v, string nm);
    req_valid = 1'b1;
    res_ready = 1'b1;
    set_req(v.op, v.a, v.b, v.tag);
    cyc();
    req_valid = 1'b0;
    chk({nm, "_x1"}, 64'(sub_x1), 64'(v.a));
    chk({nm, "_x2"}, 64'(sub_x2), 64'(v.x2));
    ovf_clear = v.clr;
    cyc();
    ovf_clear = 1'b0;
    chk({nm, "_valid"}, 64'(res_valid), 64'd1);
    chk({nm, "_data"}, 64'(res_data), 64'(v.d));
    chk({nm, "_ovf"}, 64'(res_ovf), 64'(v.o));
    chk({nm, "_tag"}, 64'(res_tag), 64'(v.tag));
    chk({nm, "_sticky"}, 64'(ovf_sticky), 64'(v.st));
    cyc();
  endtask

  task automatic drain(string nm);
    req_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 20 && held > 0; i++) cyc();
    chk({nm, "_drained"}, 64'(held), 64'd0);
  endtask

  initial begin
    logic a, p;
    int idx;
    tbl[0] = '{1'b0, 32'h40400000, 32'h3F800000, 5'd3,
               32'h3F800000, 32'h40000000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 32'h3F800000, 32'h3F800000, 5'd7,
               32'hBF800000, 32'h40000000, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 32'h7F7FFFFF, 32'hFF7FFFFF, 5'd9,
               32'hFF7FFFFF, 32'h7F800000, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 32'h40200000, 32'h3F000000, 5'd1,
               32'h3F000000, 32'h40000000, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 32'h3FC00000, 32'h40100000, 5'd30,
               32'hC0100000, 32'h40700000, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 32'h40A00000, 32'h40A00000, 5'd12,
               32'h40A00000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 32'hC0000000, 32'h40000000, 5'd31,
               32'hC0000000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 32'h7F000000, 32'h7F7FFFFF, 5'd17,
               32'hFF7FFFFF, 32'h7F800000, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 32'h3F800000, 32'h7FC12345, 5'd5,
               32'hFFC12345, 32'h7FC00000, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    req_valid = 1'b0;
    set_req(1'b0, '0, '0, '0);
    res_ready = 1'b0;
    ovf_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_data", 64'(res_data), 64'd0);
    chk("rst_tag", 64'(res_tag), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_sticky", 64'(ovf_sticky), 64'd0);
    chk("rst_x1", 64'(sub_x1), 64'd0);
    chk("rst_x2", 64'(sub_x2), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    rst = 1'b0;

    // directed table; clear pulse sits between entries 4 and 5
    for (int i = 0; i < 9; i++) begin
      if (i == 5) begin
        ovf_clear = 1'b1;
        cyc();
        ovf_clear = 1'b0;
        chk("clr_sticky", 64'(ovf_sticky), 64'd0);
      end
      apply_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // empty FIFO with res_ready high: nothing moves
    res_ready = 1'b1;
    cyc();
    chk("idle_valid", 64'(res_valid), 64'd0);

    // backpressure: tags 0..3 with consumer stalled
    res_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 10 && idx < 3; i++) begin
      req_valid = 1'b1;
      set_req(1'($urandom_range(0, 1)), rnd_norm(), rnd_norm(),
              5'(idx));
      cycle(a, p);
      if (a) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd3);
    chk("bp_inflight", 64'(inflight), 64'd3);
    set_req(1'b0, rnd_norm(), rnd_norm(), 5'd3);
    chk("bp_ready", 64'(req_ready), 64'd0);
    cycle(a, p);
    chk("bp_stall", 64'(a), 64'd0);
    res_ready = 1'b1;
    cycle(a, p);
    chk("bp_take3", 64'(a), 64'd1);
    drain("bp");

    // streaming: 16 back-to-back ops
    res_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1;
      set_req(1'($urandom_range(0, 1)), rnd_norm(), rnd_norm(),
              5'(i));
      cycle(a, p);
      chk("st_acc", 64'(a), 64'd1);
      chk("st_pop", 64'(p), 64'(i >= 2));
    end
    drain("st");

    // random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      res_ready = ($urandom_range(0, 3) != 0);
      set_req(1'($urandom_range(0, 1)), rnd_norm(), rnd_norm(),
              5'($urandom));
      cycle(a, p);
    end
    drain("rnd");

    // reset with three ops held and sticky set
    res_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 10 && idx < 3; i++) begin
      req_valid = 1'b1;
      if (idx == 0) set_req(1'b0, 32'h7F7FFFFF, 32'hFF7FFFFF, 5'd4);
      else set_req(1'b0, rnd_norm(), rnd_norm(), 5'(idx));
      cycle(a, p);
      if (a) idx++;
    end
    req_valid = 1'b0;
    chk("mr_inflight", 64'(inflight), 64'd3);
    chk("mr_sticky", 64'(ovf_sticky), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_valid", 64'(res_valid), 64'd0);
    chk("mr_infl0", 64'(inflight), 64'd0);
    chk("mr_stk0", 64'(ovf_sticky), 64'd0);
    chk("mr_x1", 64'(sub_x1), 64'd0);
    q.delete();
    held = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_vec(tbl[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=done");
    $fatal(1);
  end

endmodule
